// File: rtl/dmx_pkg.sv
// Shared DMX512 constants, arbitration decision type and channel address check.
package dmx_pkg;

   localparam int DMX_CHANNELS = 512;
   localparam int DMX_ADDR_W   = 10;
   localparam int DMX_DATA_W   = 8;

   localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

   // Per-cycle arbitration decision of the write arbiter.
   typedef enum logic [1:0] {
      ARB_OPEN    = 2'd0,   // no live owner: round-robin from last+1
      ARB_LOCKED  = 2'd1,   // owner below burst limit keeps the port
      ARB_PREEMPT = 2'd2,   // owner at burst limit, others waiting: hand over
      ARB_RENEW   = 2'd3    // owner at burst limit, nobody else waiting: restart burst
   } arb_mode_e;

   // A channel address is legal when it names one of channels 1..512.
   function automatic logic dmx_addr_legal(input logic [31:0] addr);
      return (addr >= 32'd1) && (addr <= 32'(DMX_CHANNELS));
   endfunction

endpackage

// File: rtl/dmx_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  grant,
   output logic          found
);

   int idx;

   // Scan from start upward with wrap-around; the first requester found wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmx_write_arbiter.sv
// Round-robin write-port arbiter with burst lock in front of the dmx512 transmitter.
module dmx_write_arbiter
   import dmx_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = DMX_ADDR_W,
   parameter int DATA_W    = DMX_DATA_W,
   parameter int MAX_BURST = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [ADDR_W-1:0]           write_addr,
   output logic [DATA_W-1:0]           write_data,
   output logic                        write_en,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        addr_err,
   output logic [15:0]                 err_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef logic [IDX_W-1:0] idx_t;

   // Arbitration state.
   logic              owner_valid;
   idx_t              owner;
   idx_t              last;
   logic [CNT_W-1:0]  burst_cnt;

   // Decision signals.
   arb_mode_e          mode;
   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick_grant;
   logic               pick_found;
   idx_t               pick_start;
   logic [NUM_REQ-1:0] grant;
   idx_t               grant_idx;
   logic               accept;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_legal;

   function automatic idx_t idx_next(input idx_t i);
      return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
   endfunction

   // Classify the cycle and choose what the round-robin picker searches.
   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
      mode            = ARB_OPEN;
      if (owner_valid && req_valid[owner]) begin
         if (burst_cnt < CNT_W'(MAX_BURST))
            mode = ARB_LOCKED;
         else if ((req_valid & ~owner_oh) != '0)
            mode = ARB_PREEMPT;
         else
            mode = ARB_RENEW;
      end
      pick_req   = req_valid;
      pick_start = idx_next(last);
      if (mode == ARB_PREEMPT) begin
         pick_req   = req_valid & ~owner_oh;
         pick_start = idx_next(owner);
      end
   end

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req   (pick_req),
      .start (pick_start),
      .grant (pick_grant),
      .found (pick_found)
   );

   // One-hot grant; nothing is accepted while reset is asserted.
   always_comb begin
      grant = '0;
      if (!rst) begin
         if (mode == ARB_LOCKED || mode == ARB_RENEW)
            grant = owner_oh;
         else if (pick_found)
            grant = pick_grant;
      end
   end

   assign req_ready = grant;
   assign accept    = |grant;

   // Encode the one-hot grant into the winning requester index.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) grant_idx = idx_t'(i);
   end

   assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
   assign sel_legal = dmx_addr_legal(32'(sel_addr));

   // Track the lock owner, its burst length and the round-robin pointer.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         owner_valid <= 1'b0;
         owner       <= '0;
         last        <= idx_t'(NUM_REQ - 1);
         burst_cnt   <= '0;
      end else if (accept) begin
         last <= grant_idx;
         if (req_lock[grant_idx]) begin
            owner_valid <= 1'b1;
            owner       <= grant_idx;
            // Only a continuing burst counts up; a new owner or a renewed burst restarts at 1.
            if (mode == ARB_LOCKED)
               burst_cnt <= burst_cnt + 1'b1;
            else
               burst_cnt <= CNT_W'(1);
         end else begin
            owner_valid <= 1'b0;
            burst_cnt   <= '0;
         end
      end else if (owner_valid && !req_valid[owner]) begin
         owner_valid <= 1'b0;
         burst_cnt   <= '0;
      end
   end

   // Register the transmitter write port and the address-error reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         grant_id   <= '0;
         addr_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         write_en <= accept && sel_legal;
         addr_err <= accept && !sel_legal;
         if (accept)
            grant_id <= grant_idx;
         // Address and data hold their last values through idle and dropped cycles.
         if (accept && sel_legal) begin
            write_addr <= sel_addr;
            write_data <= sel_data;
         end
         if (accept && !sel_legal && err_count != ERR_COUNT_MAX)
            err_count <= err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_dmx_write_arbiter.sv
// Directed scoreboard bench for dmx_write_arbiter.
module tb_dmx_write_arbiter;

   localparam int NR = 4;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int MB = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_lock;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic [AW-1:0]     write_addr;
   logic [DW-1:0]     write_data;
   logic              write_en;
   logic [1:0]        grant_id;
   logic              addr_err;
   logic [15:0]       err_count;

   dmx_write_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_lock(req_lock),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
      .grant_id(grant_id), .addr_err(addr_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          lock;
   } req_t;

   typedef struct {
      int            gid;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   req_t rq [NR][$];
   exp_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int evt_cnt, evt_first, evt_last;
   bit drv_en = 1'b0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_req(input int r, input int addr, input int data, input bit lock);
      req_t it;
      it.addr = AW'(addr);
      it.data = DW'(data);
      it.lock = lock;
      rq[r].push_back(it);
   endtask

   task automatic expect_wr(input int gid, input int addr, input int data, input bit err);
      exp_t e;
      e.gid  = gid;
      e.addr = AW'(addr);
      e.data = DW'(data);
      e.err  = err;
      exp_q.push_back(e);
   endtask

   function automatic bit busy();
      bit b = (exp_q.size() != 0);
      for (int r = 0; r < NR; r++) if (rq[r].size() != 0) b = 1'b1;
      return b;
   endfunction

   // Requester model: present queue heads, pop on handshake.
   initial begin
      logic [NR-1:0] rdy;
      forever begin
         @(negedge clk);
         if (drv_en) begin
            for (int r = 0; r < NR; r++) begin
               if (rq[r].size() != 0) begin
                  req_valid[r]            = 1'b1;
                  req_lock[r]             = rq[r][0].lock;
                  req_addr[r*AW +: AW]    = rq[r][0].addr;
                  req_data[r*DW +: DW]    = rq[r][0].data;
               end else begin
                  req_valid[r] = 1'b0;
                  req_lock[r]  = 1'b0;
               end
            end
            #1;
            rdy = req_ready;
            check("ready_onehot", 32'($onehot0(rdy)), 32'd1);
            check("ready_without_valid", 32'(rdy & ~req_valid), 32'd0);
            @(posedge clk);
            for (int r = 0; r < NR; r++)
               if (rdy[r] && rq[r].size() != 0) void'(rq[r].pop_front());
         end
      end
   end

   // Output monitor: every write_en or addr_err pulse consumes one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && (write_en || addr_err)) begin
            if (evt_cnt == 0) evt_first = cyc;
            evt_last = cyc;
            evt_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'({write_en, addr_err}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("write_en", 32'(write_en), 32'(!e.err));
               check("addr_err", 32'(addr_err), 32'(e.err));
               check("grant_id", 32'(grant_id), 32'(e.gid));
               if (!e.err) begin
                  check("write_addr", 32'(write_addr), 32'(e.addr));
                  check("write_data", 32'(write_data), 32'(e.data));
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_phase();
      evt_cnt   = 0;
      evt_first = 0;
      evt_last  = 0;
   endtask

   // Wait for all requests and outputs to drain; outputs must be back-to-back.
   task automatic finish_phase(input string name, input int n);
      int t = 0;
      while (busy() && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({name, "_drain_timeout"}, 32'(busy()), 32'd0);
      if (busy()) begin
         for (int r = 0; r < NR; r++) rq[r].delete();
         exp_q.delete();
      end
      check({name, "_events"}, 32'(evt_cnt), 32'(n));
      check({name, "_span"}, 32'(evt_last - evt_first + 1), 32'(n));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_data  = '0;
      evt_cnt   = 0;
      evt_first = 0;
      evt_last  = 0;

      // Reset state, with requests present to show ready stays low.
      repeat (2) @(negedge clk);
      req_valid = 4'hF;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_write_en", 32'(write_en), 32'd0);
      check("rst_write_addr", 32'(write_addr), 32'd0);
      check("rst_write_data", 32'(write_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst    = 1'b0;
      drv_en = 1'b1;
      mon_en = 1'b1;

      // Single requester, boundary addresses 1 and 512.
      start_phase();
      add_req(0, 1, 8'h10, 1'b0);
      add_req(0, 512, 8'hFF, 1'b0);
      expect_wr(0, 1, 8'h10, 1'b0);
      expect_wr(0, 512, 8'hFF, 1'b0);
      finish_phase("single", 2);
      @(negedge clk);
      check("idle_write_en", 32'(write_en), 32'd0);
      check("idle_hold_addr", 32'(write_addr), 32'd512);
      check("idle_hold_data", 32'(write_data), 32'hFF);

      // Fairness: all four continuously valid, order 0,1,2,3 repeating.
      do_reset();
      start_phase();
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < 3; k++)
            add_req(r, 10*r + k + 1, 16*r + k, 1'b0);
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < NR; r++)
            expect_wr(r, 10*r + k + 1, 16*r + k, 1'b0);
      finish_phase("fair", 12);

      // Burst lock under contention: 16 to req 1, one to req 2, then req 1 resumes.
      do_reset();
      start_phase();
      for (int k = 0; k < 20; k++) add_req(1, 100 + k, 8'h40 + k, 1'b1);
      add_req(2, 200, 8'hA5, 1'b0);
      for (int k = 0; k < 16; k++) expect_wr(1, 100 + k, 8'h40 + k, 1'b0);
      expect_wr(2, 200, 8'hA5, 1'b0);
      for (int k = 16; k < 20; k++) expect_wr(1, 100 + k, 8'h40 + k, 1'b0);
      finish_phase("burst", 21);

      // Lock without contention: 20 back-to-back grants to req 1.
      do_reset();
      start_phase();
      for (int k = 0; k < 20; k++) add_req(1, 300 + k, 8'h80 + k, 1'b1);
      for (int k = 0; k < 20; k++) expect_wr(1, 300 + k, 8'h80 + k, 1'b0);
      finish_phase("solo_lock", 20);

      // Illegal addresses 0 and 513 are dropped, then a legal write proceeds.
      do_reset();
      start_phase();
      add_req(0, 0, 8'h11, 1'b0);
      add_req(0, 513, 8'h22, 1'b0);
      add_req(0, 7, 8'h77, 1'b0);
      expect_wr(0, 0, 8'h11, 1'b1);
      expect_wr(0, 513, 8'h22, 1'b1);
      expect_wr(0, 7, 8'h77, 1'b0);
      finish_phase("illegal", 3);
      @(negedge clk);
      check("err_count_after_illegal", 32'(err_count), 32'd2);
      check("illegal_hold_addr", 32'(write_addr), 32'd7);
      check("illegal_hold_data", 32'(write_data), 32'h77);

      // Reset in the middle of a locked burst, driven directly.
      @(posedge clk);
      drv_en = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      req_valid = 4'b0010;
      req_lock  = 4'b0010;
      req_addr  = {10'd4, 10'd3, 10'd9, 10'd1};
      req_data  = {8'hD4, 8'hD3, 8'h99, 8'hD1};
      repeat (3) @(negedge clk);
      check("burst_before_rst_en", 32'(write_en), 32'd1);
      check("burst_before_rst_gid", 32'(grant_id), 32'd1);
      rst = 1'b1;
      #1;
      check("midburst_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("midburst_rst_write_en", 32'(write_en), 32'd0);
      check("midburst_rst_err_count", 32'(err_count), 32'd0);
      rst       = 1'b0;
      req_valid = 4'hF;
      req_lock  = 4'h0;
      req_addr  = {10'd4, 10'd3, 10'd2, 10'd1};
      #1;
      check("restart_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      check("restart_write_en", 32'(write_en), 32'd1);
      check("restart_grant_id", 32'(grant_id), 32'd0);
      check("restart_write_addr", 32'(write_addr), 32'd1);
      #1;
      check("restart_next_ready", 32'(req_ready), 32'b0010);
      req_valid = '0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmx_write_arbiter.md
Name: dmx_write_arbiter

Overview:
- Shares the single channel-write port of the dmx512 transmitter (write_addr/write_data/write_en) between NUM_REQ independent requesters, e.g. host bus, scene player and fade engine.
- Round-robin arbitration with optional burst lock and an anti-starvation burst limit.
- Drops out-of-range channel addresses and reports them.
- Sits directly in front of dmx512; its outputs connect 1:1 to the transmitter's write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, channel address width (valid channels 1..512)
- DATA_W, 8, channel value width
- MAX_BURST, 16, maximum consecutive grants to a locked owner while others wait (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester write request
- req_lock  in  NUM_REQ  per-requester burst-lock request
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester channel address (requester i at [i*ADDR_W +: ADDR_W])
- req_data  in  NUM_REQ*DATA_W  packed per-requester channel value
- req_ready  out  NUM_REQ  one-hot accept; combinational from current state and req_valid
- write_addr  out  ADDR_W  to dmx512 write_addr, registered
- write_data  out  DATA_W  to dmx512 write_data, registered
- write_en  out  1  to dmx512 write_en, registered, one-cycle pulse per write
- grant_id  out  $clog2(NUM_REQ)  index of last accepted requester, registered
- addr_err  out  1  one-cycle pulse: accepted request had an illegal address
- err_count  out  16  saturating count of dropped requests

Behaviour:
- Reset (sync): write_en=0, write_addr=0, write_data=0, grant_id=0, addr_err=0, err_count=0, owner=none, last=NUM_REQ-1, burst_cnt=0. During rst, req_ready=0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. At most one req_ready bit is high per cycle; it is never high without the matching req_valid. Requesters hold addr/data stable until accepted.
- Latency: accepted request appears on write_addr/write_data with write_en=1 on the following cycle. Throughput is one write per cycle, with no bubbles between back-to-back grants.
- Arbitration, evaluated each cycle:
  - LOCKED state: owner valid, req_valid[owner], and burst_cnt<MAX_BURST. Grant owner.
  - LOCKED state, owner at MAX_BURST: if any other requester is valid, grant round-robin from owner+1 and clear owner. If none is valid, grant owner and reset burst_cnt to 1.
  - OPEN state (no owner): round-robin search starts at last+1 modulo NUM_REQ; the first valid requester wins.
- Lock: on acceptance of requester i with req_lock[i]=1, owner<=i. burst_cnt<=1 on a new owner, otherwise +1. Owner is released (owner=none, burst_cnt=0) in any of these cases:
  - the owner is accepted with req_lock=0;
  - the owner deasserts req_valid;
  - the owner is preempted at MAX_BURST.
- last<=accepted index on every acceptance; grant_id mirrors it.
- Address check: legal iff 1<=addr<=512.
  - Illegal addresses are still accepted (ready=1) so the requester never deadlocks.
  - No write_en is issued.
  - addr_err pulses on the next cycle and err_count increments, saturating at 16'hFFFF.
  - Lock and round-robin pointer update normally.
- Idle cycles: write_en=0; write_addr/write_data hold their last values.
- Simultaneous requests: exactly one grant per cycle; the others wait with ready=0.
- Reset mid-burst: owner cleared, any pending output write_en suppressed on the next cycle.

Decomposition:
- Shared package dmx_pkg:
  - DMX_CHANNELS=512
  - DMX_ADDR_W=10
  - DMX_DATA_W=8
  - function dmx_addr_legal(addr)
- One sub-module, rr_pick: pure combinational round-robin priority picker.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and found flag.
  - Reused by future scheduler blocks.

Test Plan:
- Single requester: req 0 writes addr=1 data=8'h10, then addr=512 data=8'hFF. Response: ready same cycle; write_en pulses next cycle with matching addr/data; grant_id=0.
- Fairness: all 4 requesters valid continuously with lock=0 and last=3 after reset. Response: grant order 0,1,2,3,0,… with exactly one write_en per cycle and no gaps.
- Burst lock: req 1 locked with 20 writes queued, req 2 valid, MAX_BURST=16. Response: 16 consecutive grants to 1, then one to 2, then 1 resumes.
- Lock with no contention: req 1 locked with 20 writes, others idle. Response: 20 back-to-back grants to 1.
- Illegal address: addr=0, then addr=513. Response: both accepted; no write_en; two addr_err pulses; err_count=2. A following legal write proceeds normally.
- Reset mid-burst: assert rst for 1 cycle during a locked burst. Response: next cycle write_en=0, err_count=0; after release, arbitration restarts from requester 0.
